// File: rtl/regfile_write_arbiter.sv
// Two-writer front end for the single register-file write port: per-writer FIFOs
// drained round-robin into a registered write strobe, plus a pending-write mask.

module regfile_write_arbiter_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [3:0]  addr_i,
  input  logic [15:0] data_i,
  output logic        ready_o,
  output logic        nempty_o,
  output logic [3:0]  head_addr_o,
  output logic [15:0] head_data_o,
  output logic [15:0] pend_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][3:0]  addr_q;
  logic [DEPTH-1:0][15:0] data_q;
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   do_push;

  // No pass-through: a full FIFO refuses even when it pops on the same edge.
  assign ready_o     = (cnt_q != CW'(DEPTH));
  assign nempty_o    = (cnt_q != '0);
  assign do_push     = push_i && ready_o;
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)   rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[wr_ptr_q] <= addr_i;
      data_q[wr_ptr_q] <= data_i;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    pend_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(PW'(i) - rd_ptr_q) < cnt_q) pend_o[addr_q[i]] = 1'b1;
    end
  end
endmodule

module regfile_write_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int DROP_R0    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [3:0]  a_addr,
  input  logic [15:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [3:0]  b_addr,
  input  logic [15:0] b_data,
  input  logic        hold,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        wr_src,
  output logic [15:0] pending
);
  localparam int NCH = 2;

  logic [NCH-1:0]        in_vld, ch_rdy, ch_ne, ch_pop;
  logic [NCH-1:0][3:0]   in_addr, hd_addr;
  logic [NCH-1:0][15:0]  in_data, hd_data, ch_pend;

  logic        gnt_a, gnt_b, gnt_any, gnt_sel, drop;
  logic        wr_en_q, wr_en_d, wr_src_q, wr_src_d, last_q, last_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;

  assign in_vld  = {b_valid, a_valid};
  assign in_addr = {b_addr, a_addr};
  assign in_data = {b_data, a_data};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    regfile_write_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (in_vld[g]),
      .pop_i       (ch_pop[g]),
      .addr_i      (in_addr[g]),
      .data_i      (in_data[g]),
      .ready_o     (ch_rdy[g]),
      .nempty_o    (ch_ne[g]),
      .head_addr_o (hd_addr[g]),
      .head_data_o (hd_data[g]),
      .pend_o      (ch_pend[g])
    );
  end

  assign a_ready = ch_rdy[0];
  assign b_ready = ch_rdy[1];

  // last_q: 0 = A granted last, 1 = B granted last.
  assign gnt_a   = !hold && ch_ne[0] && (!ch_ne[1] ||  last_q);
  assign gnt_b   = !hold && ch_ne[1] && (!ch_ne[0] || !last_q);
  assign gnt_any = gnt_a | gnt_b;
  assign gnt_sel = gnt_b;
  assign ch_pop  = {gnt_b, gnt_a};
  assign drop    = (DROP_R0 != 0) && (hd_addr[gnt_sel] == 4'd0);

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_src_d  = wr_src_q;
    last_d    = last_q;
    if (gnt_any) begin
      wr_src_d = gnt_sel;
      last_d   = gnt_sel;
      if (!drop) begin
        wr_en_d   = 1'b1;
        wr_addr_d = hd_addr[gnt_sel];
        wr_data_d = hd_data[gnt_sel];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_src_q  <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
      last_q    <= last_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_src  = wr_src_q;

  always_comb begin
    pending = ch_pend[0] | ch_pend[1];
    if (wr_en_q) pending[wr_addr_q] = 1'b1;
    if (DROP_R0 != 0) pending[0] = 1'b0;
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: one default instance and one with DROP_R0=1.

module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, hold;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready, wr_en, wr_src;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data, pending;

  logic        d_a_valid;
  logic [3:0]  d_a_addr;
  logic [15:0] d_a_data;
  logic        d_a_ready, d_b_ready, d_wr_en, d_wr_src;
  logic [3:0]  d_wr_addr;
  logic [15:0] d_wr_data, d_pending;
  logic        zero1 = 1'b0;
  logic [3:0]  zero4 = 4'd0;
  logic [15:0] zero16 = 16'd0;

  logic [15:0] rf [16];
  logic [15:0] qa[$], qb[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.FIFO_DEPTH(2), .DROP_R0(0)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .hold(hold), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_src(wr_src), .pending(pending)
  );

  regfile_write_arbiter #(.FIFO_DEPTH(2), .DROP_R0(1)) dut_drop (
    .clk(clk), .reset(reset),
    .a_valid(d_a_valid), .a_ready(d_a_ready), .a_addr(d_a_addr), .a_data(d_a_data),
    .b_valid(zero1), .b_ready(d_b_ready), .b_addr(zero4), .b_data(zero16),
    .hold(zero1), .wr_en(d_wr_en), .wr_addr(d_wr_addr), .wr_data(d_wr_data),
    .wr_src(d_wr_src), .pending(d_pending)
  );

  // Register file fed by the strobe, used to confirm last-writer-wins.
  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs;
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    hold = 0; d_a_valid = 0; d_a_addr = 0; d_a_data = 0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 0;
    idle_inputs();
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_src", wr_src, 0);
    chk("rst_pending", pending, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    reset = 1;

    // Single write from A.
    a_valid = 1; a_addr = 3; a_data = 16'hABCD;
    @(negedge clk);
    a_valid = 0;
    chk("t1_e1_wr_en", wr_en, 0);
    chk("t1_e1_pend", pending, 16'h0008);
    @(negedge clk);
    chk("t1_e2_wr_en", wr_en, 1);
    chk("t1_e2_addr", wr_addr, 3);
    chk("t1_e2_data", wr_data, 16'hABCD);
    chk("t1_e2_src", wr_src, 0);
    chk("t1_e2_pend", pending, 16'h0008);
    @(negedge clk);
    chk("t1_e3_wr_en", wr_en, 0);
    chk("t1_e3_pend", pending, 0);

    // Same-address contention: A first, B wins in the register file.
    do_reset();
    a_valid = 1; a_addr = 5; a_data = 16'h0001;
    b_valid = 1; b_addr = 5; b_data = 16'h0002;
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    chk("t2_e1_pend", pending, 16'h0020);
    @(negedge clk);
    chk("t2_e2_wr_en", wr_en, 1);
    chk("t2_e2_src", wr_src, 0);
    chk("t2_e2_data", wr_data, 16'h0001);
    @(negedge clk);
    chk("t2_e3_wr_en", wr_en, 1);
    chk("t2_e3_src", wr_src, 1);
    chk("t2_e3_data", wr_data, 16'h0002);
    chk("t2_e3_pend", pending, 16'h0020);
    @(negedge clk);
    chk("t2_e4_wr_en", wr_en, 0);
    chk("t2_e4_pend", pending, 0);
    chk("t2_rf5", rf[5], 16'h0002);

    // hold with B streaming: FIFO fills, refuses, then drains without pass-through.
    do_reset();
    hold = 1; b_valid = 1; b_addr = 7; b_data = 16'h0071;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      chk("t3_hold_wr_en", wr_en, 0);
      chk("t3_hold_b_ready", b_ready, (e == 1) ? 1 : 0);
      b_data = 16'h0071 + 16'(e);
    end
    chk("t3_hold_pend", pending, 16'h0080);
    hold = 0;
    @(negedge clk);
    b_valid = 0;
    chk("t3_e5_wr_en", wr_en, 1);
    chk("t3_e5_data", wr_data, 16'h0071);
    chk("t3_e5_src", wr_src, 1);
    chk("t3_e5_b_ready", b_ready, 1);
    @(negedge clk);
    chk("t3_e6_wr_en", wr_en, 1);
    chk("t3_e6_data", wr_data, 16'h0072);
    @(negedge clk);
    chk("t3_e7_wr_en", wr_en, 0);
    chk("t3_e7_pend", pending, 0);

    // Both channels saturated for 8 edges; strobes alternate A,B from edge 2 to 11.
    do_reset();
    for (int e = 0; e <= 12; e++) begin
      if (e > 0) @(negedge clk);
      if (e >= 2 && e <= 11) begin
        chk("t4_wr_en", wr_en, 1);
        chk("t4_src_alt", wr_src, (e % 2 == 1) ? 1 : 0);
      end else if (e >= 1) begin
        chk("t4_idle_wr_en", wr_en, 0);
      end
      if (e >= 1 && wr_en) begin
        if (wr_src == 1'b0) begin
          chk("t4_sb_a_avail", (qa.size() != 0) ? 1 : 0, 1);
          if (qa.size() != 0) begin
            chk("t4_sb_a_data", wr_data, qa[0]);
            void'(qa.pop_front());
          end
        end else begin
          chk("t4_sb_b_avail", (qb.size() != 0) ? 1 : 0, 1);
          if (qb.size() != 0) begin
            chk("t4_sb_b_data", wr_data, qb[0]);
            void'(qb.pop_front());
          end
        end
      end
      if (e + 1 <= 8) begin
        a_valid = 1; a_addr = 4'(e); a_data = 16'hA000 + 16'(e);
        b_valid = 1; b_addr = 4'(e + 8); b_data = 16'hB000 + 16'(e);
        if (a_ready) qa.push_back(a_data);
        if (b_ready) qb.push_back(b_data);
      end else begin
        a_valid = 0; b_valid = 0;
      end
    end
    chk("t4_sb_a_drained", qa.size(), 0);
    chk("t4_sb_b_drained", qb.size(), 0);

    // Reset mid-burst discards everything.
    do_reset();
    hold = 1;
    a_valid = 1; a_addr = 9;  a_data = 16'h0009;
    b_valid = 1; b_addr = 10; b_data = 16'h000A;
    repeat (2) @(negedge clk);
    a_valid = 0; b_valid = 0; hold = 0;
    @(negedge clk);
    chk("t5_pre_wr_en", wr_en, 1);
    chk("t5_pre_pend", pending, 16'h0600);
    #2 reset = 0;
    #1;
    chk("t5_async_wr_en", wr_en, 0);
    chk("t5_async_pend", pending, 0);
    chk("t5_async_a_ready", a_ready, 1);
    chk("t5_async_b_ready", b_ready, 1);
    @(negedge clk);
    reset = 1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      chk("t5_no_stale_wr_en", wr_en, 0);
      chk("t5_no_stale_pend", pending, 0);
    end
    a_valid = 1; a_addr = 12; a_data = 16'h00C0;
    b_valid = 1; b_addr = 13; b_data = 16'h00D0;
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    chk("t5_first_src", wr_src, 0);
    chk("t5_first_addr", wr_addr, 12);
    @(negedge clk);
    chk("t5_second_src", wr_src, 1);
    chk("t5_second_addr", wr_addr, 13);

    // DROP_R0 instance: addr 0 consumes a slot but never strobes.
    do_reset();
    d_a_valid = 1; d_a_addr = 0; d_a_data = 16'h1111;
    @(negedge clk);
    d_a_addr = 1; d_a_data = 16'h2222;
    chk("t6_e1_wr_en", d_wr_en, 0);
    chk("t6_e1_pend", d_pending, 0);
    @(negedge clk);
    d_a_valid = 0;
    chk("t6_e2_wr_en", d_wr_en, 0);
    chk("t6_e2_src", d_wr_src, 0);
    chk("t6_e2_pend", d_pending, 16'h0002);
    @(negedge clk);
    chk("t6_e3_wr_en", d_wr_en, 1);
    chk("t6_e3_addr", d_wr_addr, 1);
    chk("t6_e3_data", d_wr_data, 16'h2222);
    chk("t6_e3_pend", d_pending, 16'h0002);
    @(negedge clk);
    chk("t6_e4_wr_en", d_wr_en, 0);
    chk("t6_e4_pend", d_pending, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
